memory_access: RTL and testbench
================================

# memory_access

LC-3 data-memory access stage, directly downstream of the effective-address unit. It latches the 16-bit effective address (EA) together with an access opcode, then performs one of LD, LDI, ST or STI over a single-outstanding request/ready memory handshake. Indirect forms fetch the pointer first. Loads return the data word and the NZP condition code to the register-file writeback path.

## Interface
- TIMEOUT_CYCLES, 16: cycles a request may stall before abort. Used only with MEM_TIMEOUT_EN.
- CLK  input  1  system clock; all state changes on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- START  input  1  begin an access; sampled only in IDLE.
- OP  input  2  OP[1] = store (1) or load (0); OP[0] = indirect.
- EA  input  16  effective address from the EA stage; latched at START.
- SR_DATA  input  16  store data; latched at START.
- MEM_ADDR  output  16  memory address.
- MEM_WDATA  output  16  memory write data.
- MEM_REQ  output  1  request valid.
- MEM_WE  output  1  write enable, qualified by MEM_REQ.
- MEM_RDATA  input  16  read data, valid in any cycle with MEM_REQ & MEM_READY & !MEM_WE.
- MEM_READY  input  1  memory completes the current request this cycle.
- DR_DATA  output  16  last loaded word.
- CC  output  3  NZP flags of the last loaded word.
- BUSY  output  1  high in every state except IDLE.
- DONE  output  1  one-cycle completion pulse.
- ERR  output  1  one-cycle abort pulse, coincident with DONE.

## Operation
- States: IDLE, PTR, DATA, FIN.
- IDLE, START=1: latch EA, SR_DATA and OP. Go to PTR if OP[0], else DATA. START while BUSY is ignored.
- PTR: MEM_REQ=1, MEM_WE=0, MEM_ADDR=latched EA. On MEM_READY, latch MEM_RDATA as the new address and go to DATA.
- DATA: MEM_REQ=1, MEM_ADDR=current address, MEM_WE=OP[1], MEM_WDATA=latched SR_DATA. On MEM_READY, go to FIN.
  - Load: DR_DATA <= MEM_RDATA; CC <= 100 if bit15 set, 010 if zero, 001 otherwise.
  - Store: DR_DATA and CC unchanged.
- FIN: DONE=1, then return to IDLE.
- MEM_ADDR, MEM_WE and MEM_WDATA are stable while MEM_REQ=1 and MEM_READY=0.
- Each MEM_READY cycle completes exactly one transaction. PTR→DATA keeps MEM_REQ high with the new address; the memory treats this as a new request.
- Outside PTR/DATA: MEM_REQ=0, MEM_WE=0.
- Reset values: MEM_ADDR=0, MEM_WDATA=0, MEM_REQ=0, MEM_WE=0, DR_DATA=0, CC=010, BUSY=0, DONE=0, ERR=0, state IDLE.
- RESET mid-access drops MEM_REQ immediately (asynchronously). The access is abandoned and no DONE is produced.

## Timing
- START sampled at edge k.
- Direct access, zero-wait memory:
  - MEM_REQ high in cycle k+1.
  - DONE in cycle k+2.
  - DR_DATA/CC valid from cycle k+2.
- Indirect access, zero-wait memory:
  - Pointer request in cycle k+1.
  - Data request in cycle k+2.
  - DONE in cycle k+3.
- Each wait state (MEM_READY=0 while MEM_REQ=1) adds one cycle.
- BUSY rises at k+1 and falls in the cycle after DONE. Earliest next accepted START is the edge ending the first IDLE cycle.

## Configuration
- MEM_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to PTR/DATA and increments each cycle with MEM_REQ & !MEM_READY.
  - When it reaches TIMEOUT_CYCLES, the block drops MEM_REQ and goes to FIN with ERR=1.
  - DR_DATA and CC are unchanged on abort.
  - MEM_READY arriving in the same cycle the limit is reached wins: normal completion, no ERR.
- MEM_TIMEOUT_EN undefined: waits indefinitely, ERR tied to 0, no counter logic.

## Structure
- Shared package/include lc3_defs:
  - OP bit positions.
  - State encodings (2-bit).
  - NZP constants (CC_N=100, CC_Z=010, CC_P=001).
- Sub-module nzp_gen: combinational 16-bit word → 3-bit NZP. The register-writeback path reuses it.

## Test plan
- LD, EA=0x3000, memory[0x3000]=0x8001, zero-wait → MEM_REQ at k+1 with MEM_ADDR=0x3000, DONE at k+2, DR_DATA=0x8001, CC=100.
- LDI, EA=0x3001, memory[0x3001]=0x4000, memory[0x4000]=0x0000 → addresses 0x3001 then 0x4000 on consecutive cycles, DONE at k+3, DR_DATA=0, CC=010.
- STI, EA=0x3002→0x5000, SR_DATA=0x1234, two wait states per request → write to 0x5000 with data 0x1234 and MEM_WE=1, DONE at k+7, CC unchanged.
- START pulsed during BUSY, and EA/SR_DATA changed mid-access → second START ignored, original latched address and data used.
- RESET asserted while MEM_REQ=1 in DATA → MEM_REQ=0 immediately, BUSY=0, no DONE, CC=010.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, MEM_READY held low → MEM_REQ high 4 cycles, then DONE=ERR=1 one cycle, DR_DATA unchanged.

Source files
------------

// File: rtl/lc3_defs.sv
// Shared LC-3 memory-stage definitions: opcode bit positions, FSM encodings, NZP codes.
// Pure declarations, no timing.
// No flow control of its own.
package lc3_defs;

    localparam int OP_IND   = 0;
    localparam int OP_STORE = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PTR  = 2'd1,
        ST_DATA = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    localparam logic [2:0] CC_N = 3'b100;
    localparam logic [2:0] CC_Z = 3'b010;
    localparam logic [2:0] CC_P = 3'b001;

    // Request captured at START; addr is overwritten by the pointer on indirect ops.
    typedef struct packed {
        logic [1:0]  op;
        logic [15:0] addr;
        logic [15:0] wdata;
    } req_t;

endpackage

// File: rtl/nzp_gen.sv
// Word to NZP condition-code encoder, shared with the register writeback path.
// Latency: combinational.
// Backpressure: none.
module nzp_gen
    import lc3_defs::*;
(
    input  logic [15:0] word,
    output logic [2:0]  nzp
);

    always_comb begin
        if (word[15])
            nzp = CC_N;
        else if (word == 16'h0000)
            nzp = CC_Z;
        else
            nzp = CC_P;
    end

endmodule

// File: rtl/memory_access.sv
// LC-3 LD/LDI/ST/STI memory stage; optional request abort under `MEM_TIMEOUT_EN.
// Latency: DONE 2 cycles after START (direct), 3 (indirect), plus one per wait state.
// Backpressure: holds MEM_REQ and address/data stable until MEM_READY; START ignored while BUSY.
module memory_access
    import lc3_defs::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [1:0]  OP,
    input  logic [15:0] EA,
    input  logic [15:0] SR_DATA,
    output logic [15:0] MEM_ADDR,
    output logic [15:0] MEM_WDATA,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    input  logic [15:0] MEM_RDATA,
    input  logic        MEM_READY,
    output logic [15:0] DR_DATA,
    output logic [2:0]  CC,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR
);

    state_t      state, state_nxt;
    req_t        req_q;
    logic [15:0] dr_q;
    logic [2:0]  cc_q;
    logic [2:0]  rd_nzp;
    logic        latch_start, latch_ptr, latch_load;
    logic        to_limit;

    nzp_gen u_nzp (
        .word (MEM_RDATA),
        .nzp  (rd_nzp)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        latch_start = 1'b0;
        latch_ptr   = 1'b0;
        latch_load  = 1'b0;
        MEM_REQ     = 1'b0;
        MEM_WE      = 1'b0;
        BUSY        = 1'b1;
        DONE        = 1'b0;
        case (state)
            ST_IDLE: begin
                BUSY = 1'b0;
                if (START) begin
                    latch_start = 1'b1;
                    state_nxt   = OP[OP_IND] ? ST_PTR : ST_DATA;
                end
            end
            ST_PTR: begin
                MEM_REQ = 1'b1;
                if (MEM_READY) begin
                    latch_ptr = 1'b1;
                    state_nxt = ST_DATA;
                end else if (to_limit) begin
                    state_nxt = ST_FIN;
                end
            end
            ST_DATA: begin
                MEM_REQ = 1'b1;
                MEM_WE  = req_q.op[OP_STORE];
                if (MEM_READY) begin
                    latch_load = !req_q.op[OP_STORE];
                    state_nxt  = ST_FIN;
                end else if (to_limit) begin
                    state_nxt = ST_FIN;
                end
            end
            ST_FIN: begin
                DONE      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            req_q <= '0;
            dr_q  <= '0;
            cc_q  <= CC_Z;
        end else begin
            if (latch_start)
                req_q <= '{op: OP, addr: EA, wdata: SR_DATA};
            if (latch_ptr)
                req_q.addr <= MEM_RDATA;
            if (latch_load) begin
                dr_q <= MEM_RDATA;
                cc_q <= rd_nzp;
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    logic [15:0] to_cnt;
    logic        err_q;

    // A READY in the limit cycle takes priority, so the abort only fires when READY is low.
    assign to_limit = (to_cnt == 16'(TIMEOUT_CYCLES - 1));
    assign ERR      = (state == ST_FIN) && err_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (latch_start || latch_ptr)
                to_cnt <= '0;
            else if (MEM_REQ && !MEM_READY)
                to_cnt <= to_cnt + 16'd1;
            if (MEM_REQ && state_nxt == ST_FIN)
                err_q <= !MEM_READY;
        end
    end
`else
    logic unused_cfg;

    assign to_limit   = 1'b0;
    assign ERR        = 1'b0;
    assign unused_cfg = ^TIMEOUT_CYCLES;
`endif

    assign MEM_ADDR  = req_q.addr;
    assign MEM_WDATA = req_q.wdata;
    assign DR_DATA   = dr_q;
    assign CC        = cc_q;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: LD/LDI/STI/ST sequences, busy-START, async reset, timeout.
module tb_memory_access;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        START = 1'b0;
    logic [1:0]  OP = 2'b00;
    logic [15:0] EA = 16'h0000;
    logic [15:0] SR_DATA = 16'h0000;
    logic [15:0] MEM_ADDR, MEM_WDATA, MEM_RDATA, DR_DATA;
    logic        MEM_REQ, MEM_WE, MEM_READY, BUSY, DONE, ERR;
    logic [2:0]  CC;

    int          wait_n = 0;
    logic        hold_ready = 1'b0;
    int          wcnt = 0;
    logic [15:0] wr_addr = 16'h0000;
    logic [15:0] wr_data = 16'h0000;
    int          n_chk = 0;
    int          n_pass = 0;

    memory_access #(.TIMEOUT_CYCLES(4)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .START     (START),
        .OP        (OP),
        .EA        (EA),
        .SR_DATA   (SR_DATA),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_WDATA (MEM_WDATA),
        .MEM_REQ   (MEM_REQ),
        .MEM_WE    (MEM_WE),
        .MEM_RDATA (MEM_RDATA),
        .MEM_READY (MEM_READY),
        .DR_DATA   (DR_DATA),
        .CC        (CC),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .ERR       (ERR)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        case (a)
            16'h3000: return 16'h8001;
            16'h3001: return 16'h4000;
            16'h4000: return 16'h0000;
            16'h3002: return 16'h5000;
            16'h3003: return 16'h0042;
            default:  return 16'hDEAD;
        endcase
    endfunction

    // Memory model: READY after wait_n stalled cycles per request; records the last write.
    assign MEM_RDATA = mem_rd(MEM_ADDR);
    assign MEM_READY = MEM_REQ && !hold_ready && (wcnt >= wait_n);

    always @(posedge CLK) begin
        if (MEM_REQ && MEM_READY) begin
            wcnt <= 0;
            if (MEM_WE) begin
                wr_addr <= MEM_ADDR;
                wr_data <= MEM_WDATA;
            end
        end else if (MEM_REQ) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
        end
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Drives START across one edge (edge k); returns at the midpoint of cycle k+1.
    task automatic start_op(input logic [1:0] op, input logic [15:0] ea, input logic [15:0] sr);
        START   = 1'b1;
        OP      = op;
        EA      = ea;
        SR_DATA = sr;
        @(negedge CLK);
        START = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge CLK);
        chk("rst_req", MEM_REQ, 1'b0);
        chk("rst_we", MEM_WE, 1'b0);
        chk("rst_addr", MEM_ADDR, 16'h0000);
        chk("rst_wdata", MEM_WDATA, 16'h0000);
        chk("rst_dr", DR_DATA, 16'h0000);
        chk("rst_cc", CC, 3'b010);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_done", DONE, 1'b0);
        chk("rst_err", ERR, 1'b0);
        RESET = 1'b0;
        @(negedge CLK);

        // LD 0x3000 -> 0x8001, zero wait
        wait_n = 0;
        start_op(2'b00, 16'h3000, 16'h0000);
        chk("ld_req", MEM_REQ, 1'b1);
        chk("ld_addr", MEM_ADDR, 16'h3000);
        chk("ld_we", MEM_WE, 1'b0);
        chk("ld_busy", BUSY, 1'b1);
        chk("ld_done_early", DONE, 1'b0);
        @(negedge CLK);
        chk("ld_done", DONE, 1'b1);
        chk("ld_err", ERR, 1'b0);
        chk("ld_req_fin", MEM_REQ, 1'b0);
        chk("ld_dr", DR_DATA, 16'h8001);
        chk("ld_cc", CC, 3'b100);
        @(negedge CLK);
        chk("ld_idle_busy", BUSY, 1'b0);
        chk("ld_idle_done", DONE, 1'b0);

        // LDI 0x3001 -> 0x4000 -> 0x0000
        start_op(2'b01, 16'h3001, 16'h0000);
        chk("ldi_ptr_addr", MEM_ADDR, 16'h3001);
        chk("ldi_ptr_req", MEM_REQ, 1'b1);
        @(negedge CLK);
        chk("ldi_data_addr", MEM_ADDR, 16'h4000);
        chk("ldi_data_req", MEM_REQ, 1'b1);
        chk("ldi_data_done", DONE, 1'b0);
        @(negedge CLK);
        chk("ldi_done", DONE, 1'b1);
        chk("ldi_dr", DR_DATA, 16'h0000);
        chk("ldi_cc", CC, 3'b010);
        @(negedge CLK);
        chk("ldi_idle", BUSY, 1'b0);

        // STI 0x3002 -> 0x5000 <= 0x1234, two wait states per request
        wait_n = 2;
        start_op(2'b11, 16'h3002, 16'h1234);
        for (int c = 1; c <= 7; c++) begin
            if (c > 1) @(negedge CLK);
            chk("sti_done_cycle", DONE, (c == 7));
            if (c <= 3) begin
                chk("sti_ptr_addr", MEM_ADDR, 16'h3002);
                chk("sti_ptr_we", MEM_WE, 1'b0);
            end else if (c <= 6) begin
                chk("sti_data_addr", MEM_ADDR, 16'h5000);
                chk("sti_data_we", MEM_WE, 1'b1);
                chk("sti_data_wdata", MEM_WDATA, 16'h1234);
            end
        end
        chk("sti_wr_addr", wr_addr, 16'h5000);
        chk("sti_wr_data", wr_data, 16'h1234);
        chk("sti_cc", CC, 3'b010);
        chk("sti_dr", DR_DATA, 16'h0000);
        @(negedge CLK);

        // ST with START and inputs wiggled while busy
        wait_n = 1;
        start_op(2'b10, 16'h6000, 16'hBEEF);
        START   = 1'b1;
        OP      = 2'b00;
        EA      = 16'h7777;
        SR_DATA = 16'h1111;
        @(negedge CLK);
        START = 1'b0;
        chk("st_busy_addr", MEM_ADDR, 16'h6000);
        chk("st_busy_wdata", MEM_WDATA, 16'hBEEF);
        chk("st_busy_we", MEM_WE, 1'b1);
        @(negedge CLK);
        chk("st_done", DONE, 1'b1);
        chk("st_wr_addr", wr_addr, 16'h6000);
        chk("st_wr_data", wr_data, 16'hBEEF);
        repeat (2) begin
            @(negedge CLK);
            chk("st_no_restart_busy", BUSY, 1'b0);
            chk("st_no_restart_req", MEM_REQ, 1'b0);
        end

        // LD 0x3003 -> 0x0042 (positive), then reset in the middle of an access
        wait_n = 0;
        start_op(2'b00, 16'h3003, 16'h0000);
        @(negedge CLK);
        chk("ldp_dr", DR_DATA, 16'h0042);
        chk("ldp_cc", CC, 3'b001);
        @(negedge CLK);
        hold_ready = 1'b1;
        start_op(2'b00, 16'h3000, 16'h0000);
        chk("rstmid_req_before", MEM_REQ, 1'b1);
        RESET = 1'b1;
        #1;
        chk("rstmid_req", MEM_REQ, 1'b0);
        chk("rstmid_busy", BUSY, 1'b0);
        chk("rstmid_we", MEM_WE, 1'b0);
        @(negedge CLK);
        RESET      = 1'b0;
        hold_ready = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            chk("rstmid_no_done", DONE, 1'b0);
            chk("rstmid_idle", BUSY, 1'b0);
        end
        chk("rstmid_cc", CC, 3'b010);
        chk("rstmid_dr", DR_DATA, 16'h0000);

`ifdef MEM_TIMEOUT_EN
        // READY never arrives: four request cycles, then DONE with ERR
        hold_ready = 1'b1;
        start_op(2'b00, 16'h3000, 16'h0000);
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) @(negedge CLK);
            chk("to_req", MEM_REQ, 1'b1);
            chk("to_no_done", DONE, 1'b0);
        end
        @(negedge CLK);
        chk("to_req_drop", MEM_REQ, 1'b0);
        chk("to_done", DONE, 1'b1);
        chk("to_err", ERR, 1'b1);
        chk("to_dr", DR_DATA, 16'h0000);
        chk("to_cc", CC, 3'b010);
        @(negedge CLK);
        chk("to_idle", BUSY, 1'b0);
        chk("to_err_clear", ERR, 1'b0);
        hold_ready = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
